// File: rtl/planificador_pkg.sv
// Shared definitions for the line-buffer sequencer: FSM state encoding and FIFO geometry.
package planificador_pkg;

   localparam int FIFO_DEPTH = 256;

   typedef logic [2:0] state_t;

   localparam state_t IDLE  = 3'd0;
   localparam state_t FILL  = 3'd1;
   localparam state_t RUN   = 3'd2;
   localparam state_t FLUSH = 3'd3;
   localparam state_t DONE  = 3'd4;

endpackage

// File: rtl/planificador_buffers_if.sv
// Pixel-stream handshake plus FIFO-chain control bundle for planificador_buffers.
// Handshake: a pixel transfers on a rising clk edge when pixel_valid & pixel_ready are both 1;
// pixel_valid may not depend on pixel_ready, and fifo_write_req/fifo_read_req mark exactly those edges.
interface planificador_buffers_if #(
   parameter int ROWS = 3
);
   logic            pixel_valid;
   logic            pixel_ready;
   logic [ROWS-2:0] fifo_full;
   logic [ROWS-2:0] fifo_empty;
   logic            fifo_write_req;
   logic            fifo_read_req;
   logic [ROWS-2:0] fifo_write_en;
   logic [ROWS-2:0] fifo_read_en;
   logic            fifo_clear;

   // Environment side: pixel source and FIFO chain
   modport master (
      output pixel_valid, fifo_full, fifo_empty,
      input  pixel_ready, fifo_write_req, fifo_read_req,
             fifo_write_en, fifo_read_en, fifo_clear
   );

   // Sequencer side
   modport slave (
      input  pixel_valid, fifo_full, fifo_empty,
      output pixel_ready, fifo_write_req, fifo_read_req,
             fifo_write_en, fifo_read_en, fifo_clear
   );
endinterface

// File: rtl/planificador_buffers_contador.sv
// contador_modulo: modulo-N counter with enable, synchronous clear and a wrap strobe.
module contador_modulo #(
   parameter int N = 256,
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic         wrap
);
   assign wrap = en & (count == W'(N - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      count <= '0;
      else if (clr)    count <= '0;
      else if (wrap)   count <= '0;
      else if (en)     count <= count + W'(1);
   end
endmodule

// File: rtl/planificador_buffers.sv
// planificador_buffers: sequences a ROWS-1 deep line-FIFO cascade from a raster pixel stream.
// Optional PLANIFICADOR_BUFFERS_CHECK_EN adds a sticky err output for FIFO over/underflow on accept.
module planificador_buffers
   import planificador_pkg::*;
#(
   parameter int IMG_WIDTH  = 256,
   parameter int IMG_HEIGHT = 256,
   parameter int ROWS       = 3,
   parameter int CNT_BITS   = 9
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   planificador_buffers_if.slave bus,
   output logic                window_valid,
   output logic [CNT_BITS-1:0] col_cnt,
   output logic [CNT_BITS-1:0] row_cnt,
   output logic                busy,
   output logic                done,
`ifdef PLANIFICADOR_BUFFERS_CHECK_EN
   output logic                err,
`endif
   output state_t              state_dbg
);
   state_t state, next_state;
   logic   streaming, accept, col_wrap, last_px, cnt_clr;

   assign streaming = (state == FILL) || (state == RUN);
   assign accept    = bus.pixel_valid & streaming;
   assign cnt_clr   = (state == DONE);
   assign state_dbg = state;

   contador_modulo #(.N(IMG_WIDTH), .W(CNT_BITS)) u_col (
      .clk(clk), .reset(reset), .en(accept), .clr(cnt_clr),
      .count(col_cnt), .wrap(col_wrap)
   );

   // Row wraps only on the very last pixel of the frame
   contador_modulo #(.N(IMG_HEIGHT), .W(CNT_BITS)) u_row (
      .clk(clk), .reset(reset), .en(accept & col_wrap), .clr(cnt_clr),
      .count(row_cnt), .wrap(last_px)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (start) next_state = FILL;
         FILL:  if (last_px) next_state = FLUSH;
                else if (accept && col_wrap && row_cnt == CNT_BITS'(ROWS - 2)) next_state = RUN;
         RUN:   if (last_px) next_state = FLUSH;
         FLUSH: next_state = DONE;
         DONE:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Masks decode the registered row counter, so they switch on the same edge as the row wrap
   always_comb begin
      bus.pixel_ready    = streaming;
      bus.fifo_write_req = accept;
      bus.fifo_read_req  = accept;
      bus.fifo_write_en  = '0;
      bus.fifo_read_en   = '0;
      bus.fifo_clear     = (state == FLUSH);
      busy               = (state != IDLE);
      done               = (state == DONE);
      if (streaming) begin
         for (int k = 0; k < ROWS - 1; k++) begin
            bus.fifo_write_en[k] = (row_cnt >= CNT_BITS'(k));
            bus.fifo_read_en[k]  = (row_cnt >= CNT_BITS'(k + 1));
         end
      end
   end

   // Registered to line up with the one-cycle read latency of the FIFO outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) window_valid <= 1'b0;
      else        window_valid <= accept && (row_cnt >= CNT_BITS'(ROWS - 1))
                                         && (col_cnt >= CNT_BITS'(ROWS - 1));
   end

`ifdef PLANIFICADOR_BUFFERS_CHECK_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) err <= 1'b0;
      else if (accept && ((|(bus.fifo_full & bus.fifo_write_en)) ||
                          (|(bus.fifo_empty & bus.fifo_read_en))))
         err <= 1'b1;
   end
`endif
endmodule
